uart_cmd_host: RTL
==================

Name: uart_cmd_host

Overview:
Host-side command master for the UART command protocol served by the system controller. It accepts one command at a time on a valid/ready request port and serialises it into frame bytes on a byte-wide TX interface (feeding a UART_TX). It then collects the response bytes from a byte-wide RX interface (fed by a UART_RX plus DATA_SYNC) and returns the read data or ALU result, or a timeout indication. It is used in the bench/host FPGA image and for loopback bring-up.

Parameters:
TIMEOUT_CYCLES, 65535, max CLK cycles allowed between response bytes (and from end of transmit to first byte); range 1..65535, 16-bit counter.

Ports:
CLK  input  1  single clock
RST  input  1  synchronous active-low reset
cmd_valid  input  1  command request valid
cmd_ready  output  1  high only in IDLE
cmd_type  input  2  0=RF write, 1=RF read, 2=ALU op with operands, 3=ALU op no operands
cmd_addr  input  4  RF address
cmd_wdata  input  8  RF write data
cmd_op_a  input  8  ALU operand A
cmd_op_b  input  8  ALU operand B
cmd_fun  input  4  ALU function
TX_P_DATA  output  8  frame byte to transmitter
TX_D_VLD  output  1  byte valid, held until accepted
TX_READY  input  1  transmitter can accept byte (not busy)
RX_P_DATA  input  8  response byte
RX_D_VLD  input  1  single-cycle response byte strobe
rsp_valid  output  1  one-cycle completion pulse
rsp_data  output  16  response payload
rsp_timeout  output  1  qualifies rsp_valid: response incomplete
stray_rx  output  1  one-cycle pulse: RX byte arrived outside WAIT_RSP

Behaviour:
- Reset (RST=0 at posedge): state=IDLE, cmd_ready=1, TX_D_VLD=0, TX_P_DATA=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, stray_rx=0, all counters 0. Reset mid-frame abandons the frame; TX_D_VLD is 0 the cycle after reset.
- Frames (byte 0 first):
  - type0: AA, {4'h0,addr}, wdata; 3 TX bytes; 0 RX bytes.
  - type1: BB, {4'h0,addr}; 2 TX bytes; 1 RX byte.
  - type2: CC, A, B, {4'h0,fun}; 4 TX bytes; 2 RX bytes.
  - type3: DD, {4'h0,fun}; 2 TX bytes; 2 RX bytes.
- Command capture: all cmd_* fields are registered on cmd_valid&&cmd_ready. Inputs are ignored outside IDLE.
- FSM: IDLE -> SEND -> WAIT_RSP -> DONE -> IDLE.
  - IDLE: waits for the handshake.
  - SEND: the cycle after capture, TX_D_VLD=1 with byte 0. A byte is transferred on TX_D_VLD&&TX_READY. The next byte is presented in the following cycle with TX_D_VLD kept high (back-to-back allowed). TX_P_DATA is stable while TX_D_VLD=1 and TX_READY=0.
  - After the last byte transfers: go to WAIT_RSP if the expected RX count is >0, else go to DONE.
  - WAIT_RSP: RX byte 0 -> rsp_data[7:0]; RX byte 1 -> rsp_data[15:8] (ALU result is LSB first). For type1, rsp_data[15:8]=0. After the final expected byte, go to DONE.
  - DONE: rsp_valid=1 for exactly one cycle, then IDLE with cmd_ready=1 the next cycle. Minimum command-to-command spacing is therefore one idle cycle.
- rsp_data is cleared to 0 on command capture and holds its value after rsp_valid until the next capture. For type0, rsp_data=0.
- Timeout:
  - The counter clears on entry to WAIT_RSP and on each RX_D_VLD.
  - When the counter reaches TIMEOUT_CYCLES with bytes still outstanding, go to DONE with rsp_timeout=1. rsp_data holds the partial bytes received.
  - rsp_timeout is 0 for normal completion and valid only with rsp_valid.
- RX_D_VLD while not in WAIT_RSP: the byte is dropped and stray_rx pulses the next cycle. Extra bytes after the final expected one follow the same rule.
- RX_D_VLD in the same cycle the counter expires: the byte wins and the counter clears.
- TX_READY is ignored when TX_D_VLD=0.
- Latency: capture at edge N -> TX_D_VLD at N+1. Last RX byte at edge M -> rsp_valid at M+1.

Test Plan:
1. RF write addr=5 data=3C, TX_READY=1 -> TX bytes AA,05,3C on 3 consecutive cycles; rsp_valid 1 cycle later with rsp_data=0000, rsp_timeout=0.
2. RF read addr=2, TX_READY toggling 1/0 -> bytes BB,02 each held until accepted; inject RX 7E -> rsp_data=007E, rsp_valid the cycle after the strobe.
3. ALU op A=0A, B=14, fun=0; inject RX 1E, 00 -> TX CC,0A,14,00; rsp_data=001E.
4. ALU no-operand fun=3, TIMEOUT_CYCLES=16; inject only RX 55 -> rsp_valid with rsp_timeout=1, rsp_data=0055, 16 cycles after the byte.
5. RX strobe in IDLE, then RST=0 during byte 1 of a type2 frame -> stray_rx pulse; after reset TX_D_VLD=0, cmd_ready=1, and the next command frames correctly.
6. cmd_valid held high continuously -> cmd_ready low from SEND through DONE; a second command is captured only after rsp_valid; no fields are sampled mid-frame.

Source files
------------

// File: rtl/uart_cmd_host_if.sv
// Signal bundle between the UART command host and its environment:
// the command request port, the TX byte port, the RX byte port and the response outputs.
interface uart_cmd_host_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_type;
   logic [3:0]  cmd_addr;
   logic [7:0]  cmd_wdata;
   logic [7:0]  cmd_op_a;
   logic [7:0]  cmd_op_b;
   logic [3:0]  cmd_fun;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        TX_READY;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_timeout;
   logic        stray_rx;

   modport slave (
      input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun,
      input  TX_READY, RX_P_DATA, RX_D_VLD,
      output cmd_ready, TX_P_DATA, TX_D_VLD, rsp_valid, rsp_data, rsp_timeout, stray_rx
   );

   modport master (
      output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun,
      output TX_READY, RX_P_DATA, RX_D_VLD,
      input  cmd_ready, TX_P_DATA, TX_D_VLD, rsp_valid, rsp_data, rsp_timeout, stray_rx
   );
endinterface

// File: rtl/uart_cmd_host.sv
// Host-side UART command master: serialises one captured command into frame bytes,
// then collects the response bytes (LSB first) or reports a timeout.
module uart_cmd_host #(
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic           CLK,
   input  logic           RST,
   uart_cmd_host_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_RSP = 2'd2, DONE = 2'd3} state_e;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   function automatic logic [7:0] frame_byte(input logic [1:0] t, input logic [1:0] idx,
                                             input logic [3:0] addr, input logic [7:0] wdata,
                                             input logic [7:0] op_a, input logic [7:0] op_b,
                                             input logic [3:0] fun);
      logic [7:0] b;
      b = 8'h00;
      case ({t, idx})
         4'b00_00: b = 8'hAA;
         4'b00_01: b = {4'h0, addr};
         4'b00_10: b = wdata;
         4'b01_00: b = 8'hBB;
         4'b01_01: b = {4'h0, addr};
         4'b10_00: b = 8'hCC;
         4'b10_01: b = op_a;
         4'b10_10: b = op_b;
         4'b10_11: b = {4'h0, fun};
         4'b11_00: b = 8'hDD;
         4'b11_01: b = {4'h0, fun};
         default:  b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [1:0] last_tx_idx(input logic [1:0] t);
      case (t)
         2'd0:    return 2'd2;
         2'd1:    return 2'd1;
         2'd2:    return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

   function automatic logic [1:0] rx_need(input logic [1:0] t);
      case (t)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd2;
      endcase
   endfunction

   state_e      state_q, state_d;
   logic [1:0]  type_q, type_d;
   logic [3:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  op_a_q, op_a_d;
   logic [7:0]  op_b_q, op_b_d;
   logic [3:0]  fun_q, fun_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [1:0]  rx_idx_q, rx_idx_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_timeout_q, rsp_timeout_d;
   logic        stray_q, stray_d;
   logic        tx_vld_q, tx_vld_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        cmd_ready_q, cmd_ready_d;

   // Next-state and output computation for the command sequencer.
   always_comb begin
      state_d       = state_q;
      type_d        = type_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      fun_d         = fun_q;
      byte_idx_d    = byte_idx_q;
      rx_idx_d      = rx_idx_q;
      tmo_cnt_d     = tmo_cnt_q;
      rsp_data_d    = rsp_data_q;
      tx_vld_d      = tx_vld_q;
      tx_data_d     = tx_data_q;
      rsp_timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               type_d     = bus.cmd_type;
               addr_d     = bus.cmd_addr;
               wdata_d    = bus.cmd_wdata;
               op_a_d     = bus.cmd_op_a;
               op_b_d     = bus.cmd_op_b;
               fun_d      = bus.cmd_fun;
               byte_idx_d = 2'd0;
               rsp_data_d = 16'h0000;
               tx_vld_d   = 1'b1;
               tx_data_d  = frame_byte(bus.cmd_type, 2'd0, bus.cmd_addr, bus.cmd_wdata,
                                       bus.cmd_op_a, bus.cmd_op_b, bus.cmd_fun);
               state_d    = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            if (bus.TX_READY) begin
               if (byte_idx_q == last_tx_idx(type_q)) begin
                  tx_vld_d  = 1'b0;
                  tmo_cnt_d = 16'h0000;
                  rx_idx_d  = 2'd0;
                  state_d   = (rx_need(type_q) == 2'd0) ? DONE : WAIT_RSP;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  tx_data_d  = frame_byte(type_q, byte_idx_q + 2'd1, addr_q, wdata_q,
                                          op_a_q, op_b_q, fun_q);
               end
            end else begin
               state_d = SEND;
            end
         end
         WAIT_RSP: begin
            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (bus.RX_D_VLD) begin
               tmo_cnt_d = 16'h0000;
               if (rx_idx_q == 2'd0) begin
                  rsp_data_d[7:0] = bus.RX_P_DATA;
               end else begin
                  rsp_data_d[15:8] = bus.RX_P_DATA;
               end
               if ((rx_idx_q + 2'd1) == rx_need(type_q)) begin
                  state_d = DONE;
               end else begin
                  rx_idx_d = rx_idx_q + 2'd1;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               rsp_timeout_d = 1'b1;
               state_d       = DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      rsp_valid_d = (state_d == DONE);
      cmd_ready_d = (state_d == IDLE);
      stray_d     = bus.RX_D_VLD && (state_q != WAIT_RSP);
   end

   // State and registered-output update with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q       <= IDLE;
         type_q        <= 2'd0;
         addr_q        <= 4'h0;
         wdata_q       <= 8'h00;
         op_a_q        <= 8'h00;
         op_b_q        <= 8'h00;
         fun_q         <= 4'h0;
         byte_idx_q    <= 2'd0;
         rx_idx_q      <= 2'd0;
         tmo_cnt_q     <= 16'h0000;
         rsp_data_q    <= 16'h0000;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         stray_q       <= 1'b0;
         tx_vld_q      <= 1'b0;
         tx_data_q     <= 8'h00;
         cmd_ready_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         type_q        <= type_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         fun_q         <= fun_d;
         byte_idx_q    <= byte_idx_d;
         rx_idx_q      <= rx_idx_d;
         tmo_cnt_q     <= tmo_cnt_d;
         rsp_data_q    <= rsp_data_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_timeout_q <= rsp_timeout_d;
         stray_q       <= stray_d;
         tx_vld_q      <= tx_vld_d;
         tx_data_q     <= tx_data_d;
         cmd_ready_q   <= cmd_ready_d;
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.TX_D_VLD    = tx_vld_q;
   assign bus.TX_P_DATA   = tx_data_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.stray_rx    = stray_q;
endmodule
